ext_uart_port: RTL and testbench
================================

// Module: ext_uart_port
// PURPOSE
//  Peripheral (responder) end of the core's EXT I/O ports. Accepts output bytes on
//  the EXT write port (cq/cwre/cbsy) and serialises them onto txd as 8N1 UART.
//  Deserialises 8N1 frames from rxd and offers them on the EXT read port (cd/crda/cack).
//  Sits at top level beside IROM/DRAM and is wired directly to the core's cq/cwre/cbsy/cd/crda/cack.
// PARAMETERS
//  DIVISOR     434  clk cycles per bit (50 MHz / 115200); legal range 4..65535
//  FIFO_AW     2    RX FIFO address width (depth 2**FIFO_AW); used only with EXT_UART_RX_FIFO_EN
// PORTS
//  clk         in   1  single clock; all state changes on posedge clk
//  reset       in   1  synchronous, active-low: state resets at posedge clk while reset==0
//  cq          in   8  byte to transmit; sampled when cwre==1
//  cwre        in   1  write strobe from core, one-cycle pulse
//  cbsy        out  1  transmitter busy; core must not pulse cwre while cbsy==1
//  cd          out  8  received byte; valid while crda==1
//  crda        out  1  received data available
//  cack        in   1  core consumes cd; one-cycle pulse, honoured only while crda==1
//  txd         out  1  serial output, idle high
//  rxd         in   1  serial input, asynchronous, idle high
//  rx_overrun  out  1  one-cycle pulse: a valid byte was dropped because RX storage was full
// BEHAVIOUR
//  Reset values: txd=1, cbsy=0, crda=0, cd=8'h00, rx_overrun=0; TX and RX FSMs to IDLE,
//   bit and divider counters to 0, RX storage emptied. A reset mid-frame aborts the frame;
//   txd returns to 1 on the first clock after reset is applied.
//  TX FSM IDLE->START->DATA(x8, LSB first)->STOP->IDLE; each state lasts exactly DIVISOR cycles.
//   cwre=1 && cbsy=0 at edge N: latch cq; from N+1 cbsy=1 and txd=0 (start bit).
//   cbsy stays 1 for exactly 10*DIVISOR cycles and falls in the same cycle txd finishes the stop bit.
//   cwre=1 while cbsy=1 is ignored (byte lost, no flag). A cwre in the first cycle with cbsy=0 is accepted.
//  RX front end: rxd passes through a 2-FF synchroniser (2 cycles of latency), all decisions use the synced value.
//  RX FSM IDLE->START->DATA(x8)->STOP->IDLE.
//   IDLE: a 1->0 transition on synced rxd enters START and loads divider with DIVISOR/2 (integer floor).
//   START: at mid-bit, rxd==1 -> false start, back to IDLE with no output; rxd==0 -> DATA.
//   DATA: sample every DIVISOR cycles, shift LSB first into an 8-bit register.
//   STOP: sample after DIVISOR cycles; rxd==0 -> framing error, byte discarded silently, back to IDLE;
//    rxd==1 -> byte valid, pushed to RX storage in that cycle, back to IDLE (new start detectable next cycle).
//  Read handshake: crda=1 iff storage non-empty; cd always shows the oldest byte.
//   cack=1 && crda=1 at edge N: pop; from N+1 cd shows next byte or crda=0. cack while crda=0 ignored.
//   Push and pop in the same cycle: both take effect; occupancy unchanged; never counts as overrun.
//   Push while full with no pop that cycle: byte dropped, stored data untouched, rx_overrun=1 for one cycle.
//  Latency: rxd stop-bit mid-sample to crda=1 is 1 cycle; plus 2 cycles synchroniser.
//  TX and RX are fully independent; simultaneous cwre and cack are both honoured.
// CONFIGURATION
//  EXT_UART_RX_FIFO_EN defined: RX storage is a 2**FIFO_AW-entry FIFO (pointers wrap modulo depth,
//   one extra pointer bit distinguishes full from empty); overrun only when all entries are occupied.
//  EXT_UART_RX_FIFO_EN undefined: RX storage is a single holding register (depth 1); FIFO_AW is unused;
//   a second byte arriving before cack triggers overrun.
// TESTING (DIVISOR=4 for all scenarios)
//  T1 reset: hold reset=0 for 3 clocks with rxd=0, cwre=1 -> txd=1, cbsy=0, crda=0, cd=0, rx_overrun=0 throughout.
//  T2 TX: cwre pulse with cq=8'hA5 -> txd over 40 cycles = 0,1,0,1,0,0,1,0,1,1 (4 cycles per bit);
//     cbsy=1 for exactly 40 cycles; second cwre (8'hFF) issued mid-frame -> not transmitted.
//  T3 RX: drive 8N1 frame 8'h3C on rxd -> crda=1, cd=8'h3C; cack pulse -> crda=0 next cycle.
//  T4 RX errors: 1-cycle low glitch on rxd -> no crda; frame 8'h55 with stop bit 0 -> no crda, no rx_overrun.
//  T5 overrun: without FIFO macro, send 8'h11 then 8'h22 with no cack -> cd stays 8'h11, rx_overrun pulses once;
//     with EXT_UART_RX_FIFO_EN, FIFO_AW=2, send 5 bytes 8'h01..8'h05 -> first 4 read back in order, one overrun pulse.
//  T6 concurrency: cack on the exact cycle a new byte (8'h7E) is pushed into full storage -> no rx_overrun,
//     8'h7E readable next; cwre and cack in the same cycle -> both honoured; reset mid-TX-frame -> txd=1, cbsy=0.

Source files
------------

// File: rtl/ext_uart_port.sv
// EXT I/O peripheral: byte writes become 8N1 frames on txd, 8N1 frames on rxd are offered on the read port.
// Define EXT_UART_RX_FIFO_EN for a 2**FIFO_AW-deep RX FIFO; otherwise RX storage is one holding register.
module ext_uart_port #(
    parameter int unsigned DIVISOR = 434,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cq,
    input  logic       cwre,
    output logic       cbsy,
    output logic [7:0] cd,
    output logic       crda,
    input  logic       cack,
    output logic       txd,
    input  logic       rxd,
    output logic       rx_overrun
);
    localparam logic [15:0] DIV_LAST = 16'(DIVISOR - 1);
    localparam logic [15:0] DIV_FULL = 16'(DIVISOR);
    localparam logic [15:0] DIV_HALF = 16'(DIVISOR / 2);

    if (DIVISOR < 4 || DIVISOR > 65535 || FIFO_AW < 1) begin : g_bad_param
        $error("ext_uart_port: DIVISOR or FIFO_AW out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        if (tx_state_q == S_IDLE) begin
            if (cwre) begin
                tx_state_d = S_START;
                tx_div_d   = '0;
                tx_bit_d   = '0;
                tx_sh_d    = cq;
            end
        end else if (tx_div_q == DIV_LAST) begin
            tx_div_d = '0;
            unique case (tx_state_q)
                S_START: tx_state_d = S_DATA;
                S_DATA: begin
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                end
                default: tx_state_d = S_IDLE;
            endcase
        end else begin
            tx_div_d = tx_div_q + 16'd1;
        end
    end

    always_comb begin
        txd = 1'b1;
        if (tx_state_q == S_START)     txd = 1'b0;
        else if (tx_state_q == S_DATA) txd = tx_sh_q[0];
    end

    assign cbsy = (tx_state_q != S_IDLE);

    // RX: rx_s2_q is the synchronised line; rx_prev_q is its previous value for start-edge detection.
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        push;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    // The divider counts down and the line is sampled on the cycle it reads 1.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        push       = 1'b0;
        if (rx_state_q == S_IDLE) begin
            if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = S_START;
                rx_div_d   = DIV_HALF;
                rx_bit_d   = '0;
            end
        end else if (rx_div_q != 16'd1) begin
            rx_div_d = rx_div_q - 16'd1;
        end else begin
            rx_div_d = DIV_FULL;
            unique case (rx_state_q)
                S_START: begin
                    if (rx_s2_q) begin
                        rx_state_d = S_IDLE;
                        rx_div_d   = '0;
                    end else begin
                        rx_state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
                default: begin
                    rx_state_d = S_IDLE;
                    rx_div_d   = '0;
                    push       = rx_s2_q;
                end
            endcase
        end
    end

`ifdef EXT_UART_RX_FIFO_EN
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wptr_q, rptr_q;
    logic             ovr_q, empty, full, pop, wr;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign pop   = cack && !empty;
    assign wr    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wptr_q[FIFO_AW-1:0]] <= rx_sh_q;
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) rptr_q <= rptr_q + PTR_ONE;
            ovr_q <= push && full && !pop;
        end
    end

    assign cd   = mem_q[rptr_q[FIFO_AW-1:0]];
    assign crda = !empty;
`else
    logic [7:0] hold_q;
    logic       full_q, ovr_q, pop;

    assign pop = cack && full_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (push && (!full_q || pop)) hold_q <= rx_sh_q;
            if (push)     full_q <= 1'b1;
            else if (pop) full_q <= 1'b0;
            ovr_q <= push && full_q && !pop;
        end
    end

    assign cd   = hold_q;
    assign crda = full_q;
`endif

    assign rx_overrun = ovr_q;
endmodule

// File: tb/tb_ext_uart_port.sv
// Bench for ext_uart_port at DIVISOR=4: queue/frame-level model checked every cycle plus directed literals.
// Honours EXT_UART_RX_FIFO_EN (FIFO_AW=2, depth 4) when defined.
module tb_ext_uart_port;
    localparam int D = 4;
`ifdef EXT_UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    // First edge seeing rxd low -> push edge: 2 sync, half a bit to start centre, 9 bits to stop centre.
    localparam int FRAME_LAT = 2 + D / 2 + 9 * D;

    logic       clk = 1'b0;
    logic       reset, cwre, cack, rxd;
    logic [7:0] cq;
    logic       cbsy, crda, txd, rx_overrun;
    logic [7:0] cd;

    ext_uart_port #(.DIVISOR(D), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .cq(cq), .cwre(cwre), .cbsy(cbsy),
        .cd(cd), .crda(crda), .cack(cack), .txd(txd), .rxd(rxd),
        .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0, n_fail = 0;
    int  cyc = 0, ovr_cnt = 0, base = 0, pe = 0;
    bit  chk_en = 0, chk_cd0 = 0;
    logic [9:0] tx_lit = 10'b1101001010;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    typedef struct { int edge_n; logic [7:0] b; bit stop_ok; } rx_ev_t;
    rx_ev_t     ev_q[$];
    logic [7:0] m_q[$];
    int         tx_rem = 0;
    logic [9:0] tx_frame = '1;
    bit         m_ovr = 0;

    always @(posedge clk) begin
        bit pop, push;
        rx_ev_t e;
        cyc++;
        m_ovr = 0;
        pop = 0;
        push = 0;
        if (!reset) begin
            tx_rem = 0;
            m_q.delete();
        end else begin
            if (tx_rem > 0) tx_rem--;
            else if (cwre) begin
                tx_frame = {1'b1, cq, 1'b0};
                tx_rem = 10 * D;
            end
            pop = cack && (m_q.size() > 0);
            if (ev_q.size() > 0 && ev_q[0].edge_n == cyc) begin
                e = ev_q.pop_front();
                if (e.stop_ok) begin
                    if (m_q.size() >= DEPTH && !pop) m_ovr = 1;
                    else push = 1;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(e.b);
        end
    end

    function automatic logic exp_txd();
        if (tx_rem == 0) return 1'b1;
        return tx_frame[(10 * D - tx_rem) / D];
    endfunction

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("txd", 8'(txd), 8'(exp_txd()));
            check("cbsy", 8'(cbsy), 8'(tx_rem > 0));
            check("crda", 8'(crda), 8'(m_q.size() > 0));
            if (m_q.size() > 0) check("cd", cd, m_q[0]);
            check("rx_overrun", 8'(rx_overrun), 8'(m_ovr));
            if (chk_cd0) check("cd_reset", cd, 8'h00);
        end
        if (rx_overrun === 1'b1) ovr_cnt++;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_ev_t e;
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        e.edge_n = cyc + 1 + FRAME_LAT;
        e.b = b;
        e.stop_ok = stop_bit;
        ev_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (D) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic wait_crda(input string name);
        int k = 0;
        while (crda !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, 8'(crda), 8'h01);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] b);
        check(name, cd, b);
        cack = 1'b1;
        @(negedge clk);
        cack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // T1: reset held with hostile inputs
        reset = 0; rxd = 0; cwre = 1; cq = 8'hAA; cack = 0;
        @(posedge clk);
        chk_en = 1; chk_cd0 = 1;
        repeat (3) begin
            @(negedge clk);
            check("T1 txd", 8'(txd), 8'h01);
            check("T1 cbsy", 8'(cbsy), 8'h00);
            check("T1 crda", 8'(crda), 8'h00);
            check("T1 cd", cd, 8'h00);
            check("T1 ovr", 8'(rx_overrun), 8'h00);
        end
        reset = 1; rxd = 1; cwre = 0; cq = 8'h00; chk_cd0 = 0;
        repeat (4) @(negedge clk);

        // T2: transmit A5, second write mid-frame is lost
        cq = 8'hA5; cwre = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) cwre = 0;
            check("T2 txd", 8'(txd), 8'(tx_lit[i / 4]));
            check("T2 cbsy", 8'(cbsy), 8'h01);
            if (i == 20) begin cq = 8'hFF; cwre = 1; end
            if (i == 21) cwre = 0;
        end
        @(negedge clk);
        check("T2 cbsy end", 8'(cbsy), 8'h00);
        check("T2 txd end", 8'(txd), 8'h01);
        repeat (6) @(negedge clk);
        check("T2 no resend", 8'(cbsy), 8'h00);

        // T3: receive 3C and consume it
        send_frame(8'h3C, 1'b1);
        wait_crda("T3 crda");
        check("T3 cd", cd, 8'h3C);
        cack = 1; @(negedge clk); cack = 0;
        check("T3 crda after cack", 8'(crda), 8'h00);

        // T4: glitch and framing error
        repeat (4) @(negedge clk);
        rxd = 0; @(negedge clk); rxd = 1;
        repeat (30) @(negedge clk);
        check("T4 glitch crda", 8'(crda), 8'h00);
        base = ovr_cnt;
        send_frame(8'h55, 1'b0);
        repeat (10) @(negedge clk);
        check("T4 frame err crda", 8'(crda), 8'h00);
        check("T4 frame err ovr", 8'(ovr_cnt - base), 8'h00);

        // T5: overrun
        base = ovr_cnt;
`ifdef EXT_UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (8) @(negedge clk);
        check("T5 ovr pulses", 8'(ovr_cnt - base), 8'h01);
        for (int i = 1; i <= 4; i++) begin
            check("T5 crda", 8'(crda), 8'h01);
            pop_expect("T5 cd order", 8'(i));
        end
`else
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (8) @(negedge clk);
        check("T5 ovr pulses", 8'(ovr_cnt - base), 8'h01);
        check("T5 crda", 8'(crda), 8'h01);
        pop_expect("T5 cd kept", 8'h11);
`endif
        check("T5 drained", 8'(crda), 8'h00);

        // T6: pop on the exact push edge into full storage
`ifdef EXT_UART_RX_FIFO_EN
        for (int i = 0; i < 4; i++) send_frame(8'h61 + 8'(i), 1'b1);
`else
        send_frame(8'h5A, 1'b1);
`endif
        repeat (6) @(negedge clk);
        base = ovr_cnt;
        pe = cyc + 1 + FRAME_LAT;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                for (int k = 0; k < 200 && cyc != pe - 1; k++) @(negedge clk);
                cack = 1; @(negedge clk); cack = 0;
            end
        join
        repeat (6) @(negedge clk);
        check("T6 no ovr", 8'(ovr_cnt - base), 8'h00);
        check("T6 crda", 8'(crda), 8'h01);
`ifdef EXT_UART_RX_FIFO_EN
        pop_expect("T6 cd 62", 8'h62);
        pop_expect("T6 cd 63", 8'h63);
        pop_expect("T6 cd 64", 8'h64);
`endif
        check("T6 cd 7E", cd, 8'h7E);

        // simultaneous write and consume
        cq = 8'hC3; cwre = 1; cack = 1;
        @(negedge clk);
        cwre = 0; cack = 0;
        check("T6 cwre honoured", 8'(cbsy), 8'h01);
        check("T6 cack honoured", 8'(crda), 8'h00);

        // reset mid-frame
        repeat (15) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("T6 reset txd", 8'(txd), 8'h01);
        check("T6 reset cbsy", 8'(cbsy), 8'h00);
        reset = 1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
